// File: rtl/jogo_memoria_parametrizado.sv
// Simon-style memory game: the LFSR-generated sequence grows by one element per round
// until the chosen number of rounds is won, a wrong play is made, or the play timer expires.
module jogo_memoria_parametrizado #(
    parameter int          N_BOTOES  = 4,
    parameter int          DEPTH     = 16,
    parameter int          T_LED     = 1000,
    parameter int          T_GAP     = 500,
    parameter int          T_TIMEOUT = 5000,
    parameter logic [7:0]  SEED      = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jogar,
    input  logic                    modo,
    input  logic [1:0]              nivel,
    input  logic [N_BOTOES-1:0]     botoes,
    output logic [N_BOTOES-1:0]     leds,
    output logic                    pronto,
    output logic                    ganhou,
    output logic                    perdeu,
    output logic                    timeout,
    output logic [4:0]              db_estado,
    output logic [$clog2(DEPTH):0]  db_rodada
);

    localparam int IW     = $clog2(N_BOTOES);
    localparam int RW     = $clog2(DEPTH) + 1;
    localparam int QUARTO = DEPTH / 4;
    localparam int TMAX   = (T_TIMEOUT > T_LED) ? ((T_TIMEOUT > T_GAP) ? T_TIMEOUT : T_GAP)
                                                : ((T_LED > T_GAP) ? T_LED : T_GAP);
    localparam int TW     = $clog2(TMAX + 1);

    typedef enum logic [4:0] {
        INICIAL       = 5'b00000,
        PREPARA       = 5'b00001,
        CARREGA_LED   = 5'b00010,
        MOSTRA_LED    = 5'b00011,
        PAUSA         = 5'b00100,
        PROX_LED      = 5'b00101,
        INICIA_JOGADA = 5'b00110,
        ESPERA_JOGADA = 5'b00111,
        REGISTRA      = 5'b01000,
        COMPARA       = 5'b01001,
        PROX_JOGADA   = 5'b01010,
        FIM_RODADA    = 5'b01011,
        ACERTOU       = 5'b01100,
        ERROU         = 5'b01101,
        ESTOURO       = 5'b01110
    } estado_t;

    estado_t              r_estado, w_proximo;
    logic [7:0]           r_lfsr, r_seed, r_freeCnt;
    logic [TW-1:0]        r_timer;
    logic [RW-1:0]        r_rodada, r_k, r_vitoria;
    logic [N_BOTOES-1:0]  r_jogada, r_botoesPrev;
    logic                 r_jogarPrev;

    logic                 w_jogarEdge, w_jogada, w_onehot;
    logic [7:0]           w_lfsrNext, w_seedNova;
    logic [N_BOTOES-1:0]  w_ledSeq;
    logic [RW-1:0]        w_vitoria;
    logic                 w_timerClr, w_timerInc, w_lfsrLoad, w_lfsrStep;
    logic                 w_kClr, w_kInc, w_rClr, w_rInc;
    logic                 w_seedLoad, w_jogadaLoad, w_vitoriaLoad;

    assign w_jogarEdge = jogar & ~r_jogarPrev;
    assign w_jogada    = (|botoes) & ~(|r_botoesPrev);
    assign w_lfsrNext  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_ledSeq    = {{(N_BOTOES-1){1'b0}}, 1'b1} << r_lfsr[IW-1:0];
    assign w_vitoria   = RW'((int'(nivel) + 1) * QUARTO);
    assign w_onehot    = (r_jogada != '0) &&
                         ((r_jogada & (r_jogada - N_BOTOES'(1))) == '0);
    // A captured zero would lock the LFSR, so it falls back to the fixed seed.
    assign w_seedNova  = (modo && (r_freeCnt != 8'd0)) ? r_freeCnt : SEED;

    always_comb begin
        w_proximo     = r_estado;
        w_timerClr    = 1'b0;
        w_timerInc    = 1'b0;
        w_lfsrLoad    = 1'b0;
        w_lfsrStep    = 1'b0;
        w_kClr        = 1'b0;
        w_kInc        = 1'b0;
        w_rClr        = 1'b0;
        w_rInc        = 1'b0;
        w_seedLoad    = 1'b0;
        w_jogadaLoad  = 1'b0;
        w_vitoriaLoad = 1'b0;
        case (r_estado)
            INICIAL, ACERTOU, ERROU, ESTOURO: begin
                if (w_jogarEdge) begin
                    w_seedLoad = 1'b1;
                    w_proximo  = PREPARA;
                end
            end
            PREPARA: begin
                w_vitoriaLoad = 1'b1;
                w_rClr        = 1'b1;
                w_proximo     = CARREGA_LED;
            end
            CARREGA_LED: begin
                w_lfsrLoad = 1'b1;
                w_kClr     = 1'b1;
                w_timerClr = 1'b1;
                w_proximo  = MOSTRA_LED;
            end
            MOSTRA_LED: begin
                if (r_timer == TW'(T_LED - 1)) begin
                    w_timerClr = 1'b1;
                    w_proximo  = PAUSA;
                end else begin
                    w_timerInc = 1'b1;
                end
            end
            PAUSA: begin
                if (r_timer == TW'(T_GAP - 1)) begin
                    w_timerClr = 1'b1;
                    w_proximo  = PROX_LED;
                end else begin
                    w_timerInc = 1'b1;
                end
            end
            PROX_LED: begin
                if (r_k == r_rodada) begin
                    w_proximo = INICIA_JOGADA;
                end else begin
                    w_kInc     = 1'b1;
                    w_lfsrStep = 1'b1;
                    w_timerClr = 1'b1;
                    w_proximo  = MOSTRA_LED;
                end
            end
            INICIA_JOGADA: begin
                w_lfsrLoad = 1'b1;
                w_kClr     = 1'b1;
                w_timerClr = 1'b1;
                w_proximo  = ESPERA_JOGADA;
            end
            // A play arriving on the expiry cycle takes priority over the timeout.
            ESPERA_JOGADA: begin
                if (w_jogada) begin
                    w_jogadaLoad = 1'b1;
                    w_timerClr   = 1'b1;
                    w_proximo    = REGISTRA;
                end else if (r_timer == TW'(T_TIMEOUT - 1)) begin
                    w_proximo = ESTOURO;
                end else begin
                    w_timerInc = 1'b1;
                end
            end
            REGISTRA: w_proximo = COMPARA;
            COMPARA: begin
                if (!w_onehot || (r_jogada != w_ledSeq)) w_proximo = ERROU;
                else                                      w_proximo = PROX_JOGADA;
            end
            PROX_JOGADA: begin
                if (r_k < r_rodada) begin
                    w_kInc     = 1'b1;
                    w_lfsrStep = 1'b1;
                    w_timerClr = 1'b1;
                    w_proximo  = ESPERA_JOGADA;
                end else begin
                    w_proximo = FIM_RODADA;
                end
            end
            FIM_RODADA: begin
                if ((r_rodada + RW'(1)) == r_vitoria) begin
                    w_proximo = ACERTOU;
                end else begin
                    w_rInc    = 1'b1;
                    w_proximo = CARREGA_LED;
                end
            end
            default: w_proximo = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado     <= INICIAL;
            r_lfsr       <= 8'd0;
            r_seed       <= 8'd0;
            r_freeCnt    <= 8'd0;
            r_timer      <= '0;
            r_rodada     <= '0;
            r_k          <= '0;
            r_vitoria    <= '0;
            r_jogada     <= '0;
            r_botoesPrev <= '0;
            r_jogarPrev  <= 1'b0;
        end else begin
            r_estado     <= w_proximo;
            r_freeCnt    <= r_freeCnt + 8'd1;
            r_botoesPrev <= botoes;
            r_jogarPrev  <= jogar;
            if (w_seedLoad)         r_seed    <= w_seedNova;
            if (w_vitoriaLoad)      r_vitoria <= w_vitoria;
            if (w_jogadaLoad)       r_jogada  <= botoes;
            if (w_timerClr)         r_timer   <= '0;
            else if (w_timerInc)    r_timer   <= r_timer + TW'(1);
            if (w_lfsrLoad)         r_lfsr    <= r_seed;
            else if (w_lfsrStep)    r_lfsr    <= w_lfsrNext;
            if (w_kClr)             r_k       <= '0;
            else if (w_kInc)        r_k       <= r_k + RW'(1);
            if (w_rClr)             r_rodada  <= '0;
            else if (w_rInc)        r_rodada  <= r_rodada + RW'(1);
        end
    end

    always_comb begin
        leds = '0;
        case (r_estado)
            MOSTRA_LED:    leds = w_ledSeq;
            ESPERA_JOGADA: leds = botoes;
            default:       leds = '0;
        endcase
    end

    assign ganhou    = (r_estado == ACERTOU);
    assign perdeu    = (r_estado == ERROU);
    assign timeout   = (r_estado == ESTOURO);
    assign pronto    = ganhou | perdeu | timeout;
    assign db_estado = r_estado;
    assign db_rodada = r_rodada;

endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// Directed bench for jogo_memoria_parametrizado with short timings; expected LED sequence
// for SEED=8'hA5 worked out by hand: A5,4A,95,2A -> 0010,0100,0010,0100.
module tb_jogo_memoria_parametrizado;

    logic       clock = 1'b0;
    logic       reset, jogar, modo;
    logic [1:0] nivel;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto, ganhou, perdeu, timeout;
    logic [4:0] db_estado;
    logic [4:0] db_rodada;

    int errors = 0;
    int checks = 0;

    logic [3:0] seq [4] = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};

    always #5 clock = ~clock;

    jogo_memoria_parametrizado #(
        .N_BOTOES(4), .DEPTH(16), .T_LED(4), .T_GAP(2), .T_TIMEOUT(20), .SEED(8'hA5)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .nivel(nivel),
        .botoes(botoes), .leds(leds), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado), .db_rodada(db_rodada)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitState(input logic [4:0] code, input int budget, input string tag);
        int n = 0;
        while (db_estado !== code && n < budget) begin
            @(negedge clock);
            n++;
        end
        checkOutput(tag, 32'(db_estado), 32'(code));
    endtask

    task automatic pulseJogar();
        jogar = 1'b1;
        @(negedge clock);
        jogar = 1'b0;
    endtask

    task automatic expectLed(input logic [3:0] expected, input string tag,
                             output logic [3:0] seen);
        int n = 0;
        waitState(5'b00011, 100, {tag, " mostra"});
        seen = leds;
        checkOutput(tag, 32'(leds), 32'(expected));
        while (db_estado === 5'b00011 && n < 20) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] value, input string tag);
        waitState(5'b00111, 100, {tag, " espera"});
        botoes = value;
        @(negedge clock);
        botoes = 4'b0000;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " leds"},    32'(leds),      32'd0);
        checkOutput({tag, " pronto"},  32'(pronto),    32'd0);
        checkOutput({tag, " ganhou"},  32'(ganhou),    32'd0);
        checkOutput({tag, " perdeu"},  32'(perdeu),    32'd0);
        checkOutput({tag, " timeout"}, 32'(timeout),   32'd0);
        checkOutput({tag, " estado"},  32'(db_estado), 32'd0);
        checkOutput({tag, " rodada"},  32'(db_rodada), 32'd0);
    endtask

    // The free-running counter reads m at the negedge m cycles after reset is released.
    task automatic resetAndCount(input int m);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (m) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] seen, ledA, ledB;
        int bad;
        reset = 1'b1; jogar = 1'b0; modo = 1'b0; nivel = 2'd0; botoes = 4'b0000;
        repeat (3) @(negedge clock);
        checkIdle("reset");
        reset = 1'b0;
        @(negedge clock);

        // First round: exact LED on/off timing and entry into play.
        pulseJogar();
        checkOutput("t1 prepara", 32'(db_estado), 32'd1);
        @(negedge clock);
        checkOutput("t1 carrega", 32'(db_estado), 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput($sformatf("t1 led on %0d", i), 32'(leds), 32'(4'b0010));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checkOutput($sformatf("t1 led off %0d", i), 32'(leds), 32'd0);
            checkOutput($sformatf("t1 pausa %0d", i), 32'(db_estado), 32'd4);
        end
        waitState(5'b00111, 10, "t1 espera");
        applyStimulus(seq[0], "t1 r1");
        expectLed(seq[0], "t1 r2 k0", seen);
        expectLed(seq[1], "t1 r2 k1", seen);
        checkOutput("t1 rodada", 32'(db_rodada), 32'd1);

        // Complete the four-round game.
        applyStimulus(seq[0], "t2 r2 p0");
        applyStimulus(seq[1], "t2 r2 p1");
        for (int r = 2; r < 4; r++) begin
            for (int k = 0; k <= r; k++) expectLed(seq[k], $sformatf("t2 r%0d k%0d", r, k), seen);
            for (int k = 0; k <= r; k++) applyStimulus(seq[k], $sformatf("t2 r%0d p%0d", r, k));
        end
        waitState(5'b01100, 20, "t2 acertou");
        checkOutput("t2 ganhou",  32'(ganhou),    32'd1);
        checkOutput("t2 pronto",  32'(pronto),    32'd1);
        checkOutput("t2 rodada",  32'(db_rodada), 32'd3);
        checkOutput("t2 perdeu",  32'(perdeu),    32'd0);
        checkOutput("t2 leds",    32'(leds),      32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (db_estado !== 5'b01100 || ganhou !== 1'b1 || pronto !== 1'b1 || leds !== 4'b0000)
                bad++;
        end
        checkOutput("t2 hold", 32'(bad), 32'd0);

        // Wrong (multi-hot) play, then restart without reset.
        pulseJogar();
        checkOutput("t3 prepara", 32'(db_estado), 32'd1);
        checkOutput("t3 ganhou clr", 32'(ganhou), 32'd0);
        expectLed(seq[0], "t3 r1", seen);
        applyStimulus(4'b1111, "t3 erro");
        waitState(5'b01101, 10, "t3 errou");
        checkOutput("t3 perdeu", 32'(perdeu), 32'd1);
        checkOutput("t3 pronto", 32'(pronto), 32'd1);
        pulseJogar();
        checkOutput("t3 restart", 32'(db_estado), 32'd1);
        checkOutput("t3 perdeu clr", 32'(perdeu), 32'd0);
        @(negedge clock);
        checkOutput("t3 carrega", 32'(db_estado), 32'd2);
        expectLed(seq[0], "t3 replay", seen);

        // Play timer expiry after exactly 20 idle cycles.
        waitState(5'b00111, 20, "t4 espera");
        bad = 0;
        repeat (19) begin
            @(negedge clock);
            if (db_estado !== 5'b00111) bad++;
        end
        checkOutput("t4 still waiting", 32'(bad), 32'd0);
        @(negedge clock);
        checkOutput("t4 estouro", 32'(db_estado), 32'd14);
        checkOutput("t4 timeout", 32'(timeout),   32'd1);
        checkOutput("t4 pronto",  32'(pronto),    32'd1);

        // A play on the expiry cycle is accepted.
        pulseJogar();
        checkOutput("t4 restart", 32'(db_estado), 32'd1);
        checkOutput("t4 timeout clr", 32'(timeout), 32'd0);
        expectLed(seq[0], "t4 r1", seen);
        waitState(5'b00111, 20, "t4b espera");
        repeat (19) @(negedge clock);
        botoes = 4'b0010;
        @(negedge clock);
        botoes = 4'b0000;
        checkOutput("t4 late play", 32'(db_estado), 32'd8);
        expectLed(seq[0], "t4 r2 k0", seen);
        expectLed(seq[1], "t4 r2 k1", seen);
        checkOutput("t4 rodada", 32'(db_rodada), 32'd1);
        applyStimulus(seq[0], "t4 r2 p0");
        applyStimulus(seq[1], "t4 r2 p1");

        // Reset in the middle of round 3's display.
        waitState(5'b00011, 40, "t5 mostra");
        checkOutput("t5 rodada", 32'(db_rodada), 32'd2);
        reset = 1'b1;
        @(negedge clock);
        checkIdle("t5 midreset");
        reset = 1'b0;

        // Counter-seeded games: seeds 0x0A and 0x0D, then a captured zero.
        modo = 1'b1;
        resetAndCount(10);
        pulseJogar();
        expectLed(4'b0100, "t6 seed 0A", ledA);
        resetAndCount(13);
        pulseJogar();
        expectLed(4'b0010, "t6 seed 0D", ledB);
        checkOutput("t6 differ", 32'(ledA != ledB), 32'd1);
        waitState(5'b00111, 20, "t6 espera");
        botoes = 4'b0010;
        waitState(5'b00011, 40, "t6 r2 mostra");
        checkOutput("t6 rodada", 32'(db_rodada), 32'd1);
        waitState(5'b00111, 60, "t6 r2 espera");
        repeat (8) @(negedge clock);
        checkOutput("t6 held no replay", 32'(db_estado), 32'd7);
        botoes = 4'b0000;
        resetAndCount(0);
        pulseJogar();
        expectLed(4'b0010, "t6 seed zero", seen);
        modo = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
